// File: rtl/mm_pkg.sv
// Shared header for the streaming matrix multiplier.
// Holds the engine state encoding and size helpers derived from LOG_N.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_B   = 2'd1,
    ST_STREAM_A = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  // Matrix dimension N = 2**log_n
  function automatic int unsigned mm_n(input int unsigned log_n);
    return 32'd1 << log_n;
  endfunction

  // Element count N2 = N*N
  function automatic int unsigned mm_n2(input int unsigned log_n);
    return 32'd1 << (2 * log_n);
  endfunction

endpackage

// File: rtl/mm_mac_lane.sv
// One multiply-accumulate lane of the row engine.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears acc)
//   en         accumulate this cycle
//   first      first term of a row: overwrite acc with the product
//   a_in, b_in signed operands
//   acc        running dot product, wraps modulo 2**ACC_W
module mm_mac_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = $signed(a_in) * $signed(b_in);
  // Signed size cast sign-extends the full-width product
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      // Overwriting on the first term removes the need for a clear cycle
      acc <= first ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/mm_row_stream_engine.sv
// Streaming N x N signed matrix multiplier, C = A x B.
// B is loaded row-major into an on-chip buffer, then A streams in row-major;
// N MAC lanes build one C row per N accepted A words, which is then drained
// row-major on the output port.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_start            start a job (only sampled in IDLE)
//   cfg_keep_b           with cfg_start: reuse the buffered B if it is valid
//   in_valid/in_ready    input handshake, in_data carries B then A words
//   out_valid/out_ready  output handshake, out_data = C[out_row][out_col]
//   out_last             marks C[N-1][N-1]
//   busy                 engine not idle
//   done                 one-cycle pulse after the out_last transfer
//   dbg_state            current FSM state
// Handshake rule: a word moves on a rising edge where valid and ready are both
// high; ready never depends on valid, and output data is held while
// out_valid is high and out_ready is low.
module mm_row_stream_engine
  import mm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG_N  = 2,
  parameter int ACC_W  = 2 * DATA_W + LOG_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_keep_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [LOG_N-1:0]  out_row,
  output logic [LOG_N-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam int N  = int'(mm_n(LOG_N));
  localparam int N2 = int'(mm_n2(LOG_N));
  localparam logic [LOG_N-1:0]   LAST     = LOG_N'(N - 1);
  localparam logic [2*LOG_N-1:0] IDX_LAST = (2 * LOG_N)'(N2 - 1);

  state_t               state, state_nxt;
  logic [LOG_N-1:0]     k, row, col;
  logic [2*LOG_N-1:0]   idx;
  logic                 b_valid;
  logic                 done_r;
  logic [DATA_W-1:0]    b_mem [N2];
  logic [ACC_W-1:0]     acc [N];
  logic                 in_xfer, out_xfer, lane_en;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign lane_en  = (state == ST_STREAM_A) & in_xfer;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cfg_start) state_nxt = (cfg_keep_b && b_valid) ? ST_STREAM_A : ST_LOAD_B;
      ST_LOAD_B:
        if (in_xfer && idx == IDX_LAST) state_nxt = ST_STREAM_A;
      ST_STREAM_A:
        if (in_xfer && k == LAST) state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (out_xfer && col == LAST) state_nxt = (row == LAST) ? ST_IDLE : ST_STREAM_A;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_LOAD_B:   in_ready = 1'b1;
      ST_STREAM_A: in_ready = 1'b1;
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (row == LAST) && (col == LAST);
      end
      default: ;
    endcase
  end

  // Counters and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      row     <= '0;
      col     <= '0;
      idx     <= '0;
      b_valid <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= out_xfer & out_last;
      case (state)
        ST_IDLE:
          if (cfg_start) begin
            k   <= '0;
            row <= '0;
            col <= '0;
            idx <= '0;
          end
        ST_LOAD_B:
          if (in_xfer) begin
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) b_valid <= 1'b1;
          end
        ST_STREAM_A:
          // k wraps to 0 after the last word of a row
          if (in_xfer) k <= k + 1'b1;
        ST_DRAIN:
          if (out_xfer) begin
            col <= col + 1'b1;
            if (col == LAST && row != LAST) begin
              row <= row + 1'b1;
              k   <= '0;
            end
          end
        default: ;
      endcase
    end
  end

  // B buffer: contents are meaningless until b_valid, so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && state == ST_LOAD_B && in_xfer) b_mem[idx] <= in_data;
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam logic [LOG_N-1:0] J = LOG_N'(j);
    mm_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (lane_en),
      .first (k == '0),
      .a_in  (in_data),
      .b_in  (b_mem[{k, J}]),
      .acc   (acc[j])
    );
  end

  assign out_data  = acc[col];
  assign out_row   = row;
  assign out_col   = col;
  assign done      = done_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_mm_row_stream_engine.sv
// Bench for mm_row_stream_engine at N=4, DATA_W=16, ACC_W=34.
module tb_mm_row_stream_engine;

  localparam int DATA_W = 16;
  localparam int LOG_N  = 2;
  localparam int ACC_W  = 34;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cfg_start = 1'b0, cfg_keep_b = 1'b0;
  logic              in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid, out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic [LOG_N-1:0]  out_row, out_col;
  logic              out_last, busy, done;
  logic [1:0]        dbg_state;

  mm_row_stream_engine #(.DATA_W(DATA_W), .LOG_N(LOG_N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_keep_b(cfg_keep_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic signed [DATA_W-1:0] a_m [16];
  logic signed [DATA_W-1:0] b_m [16];
  int                       exp_mode = 0;   // 0 model, 1 hand constant, 2 identity (A itself)
  logic [ACC_W-1:0]         hand_val = '0;

  // Scoreboard entry: {last, row, col, data}
  logic [ACC_W+4:0] exp_q[$];
  logic             exp_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ACC_W-1:0] model_c(input int r, input int c);
    logic signed [ACC_W-1:0] s;
    s = '0;
    for (int kk = 0; kk < 4; kk++) s = s + a_m[r*4+kk] * b_m[kk*4+c];
    return s;
  endfunction

  function automatic logic [ACC_W-1:0] exp_val(input int r, input int c);
    case (exp_mode)
      1:       return hand_val;
      2:       return ACC_W'(r * 4 + c + 1);
      default: return model_c(r, c);
    endcase
  endfunction

  // Monitor: compares every output transfer and the done pulse
  always @(negedge clk) begin
    logic [ACC_W+4:0] e;
    if (rst) begin
      exp_done = 1'b0;
    end else begin
      if (exp_done || done) chk("done_pulse", 64'(done), 64'(exp_done));
      if (done) done_cnt++;
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e[ACC_W-1:0]));
          chk("out_row",  64'(out_row),  64'(e[ACC_W+3:ACC_W+2]));
          chk("out_col",  64'(out_col),  64'(e[ACC_W+1:ACC_W]));
          chk("out_last", 64'(out_last), 64'(e[ACC_W+4]));
        end
        exp_done = out_last;
      end
    end
  end

  // Driver tasks: all start and end at posedge + #1
  task automatic send_word(input logic [DATA_W-1:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 500);
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < 4; c++)
      exp_q.push_back({(r == 3 && c == 3), 2'(r), 2'(c), exp_val(r, c)});
  endtask

  task automatic wait_idle(input int done_before);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("job_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk); #1;
    chk("done_count", 64'(done_cnt), 64'(done_before + 1));
    @(posedge clk); #1;
  endtask

  task automatic run_job(input bit kb, input bit exp_load, input int n_a, input bit gaps);
    int done_before;
    done_before = done_cnt;
    cfg_start  = 1'b1;
    cfg_keep_b = kb;
    @(posedge clk); #1;
    cfg_start  = 1'b0;
    cfg_keep_b = 1'b0;
    chk("start_state", 64'(dbg_state), exp_load ? 64'd1 : 64'd2);
    if (exp_load) for (int i = 0; i < 16; i++) begin
      gap(gaps);
      send_word(b_m[i]);
    end
    for (int i = 0; i < n_a; i++) begin
      if (i % 4 == 0) push_row(i / 4);
      gap(gaps);
      send_word(a_m[i]);
    end
    if (n_a == 16) wait_idle(done_before);
  endtask

  task automatic stall_watch();
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!(out_valid && out_row == 2'd1 && out_col == 2'd2) && t < 2000);
    if (t >= 2000) begin
      chk("stall_point_timeout", 64'(out_row), 64'd1);
    end else begin
      out_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("stall_data",  64'(out_data),  64'(model_c(1, 2)));
        chk("stall_col",   64'(out_col),   64'd2);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_inrdy", 64'(in_ready),  64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_out_row",   64'(out_row),   64'd0);
    chk("rst_out_col",   64'(out_col),   64'd0);
    chk("rst_state",     64'(dbg_state), 64'd0);

    // Identity B: C equals A
    for (int i = 0; i < 16; i++) begin
      a_m[i] = DATA_W'(i + 1);
      b_m[i] = (i / 4 == i % 4) ? 16'sd1 : 16'sd0;
    end
    exp_mode = 2;
    run_job(1'b1, 1'b1, 16, 1'b0);   // keep_b before any load falls back to LOAD_B

    // Signed: -1 x 2 summed over 4 terms
    for (int i = 0; i < 16; i++) begin
      a_m[i] = 16'shFFFF;
      b_m[i] = 16'sh0002;
    end
    exp_mode = 1;
    hand_val = 34'h3_FFFF_FFF8;
    run_job(1'b0, 1'b1, 16, 1'b0);

    // Extremes
    for (int i = 0; i < 16; i++) begin
      a_m[i] = 16'sh7FFF;
      b_m[i] = 16'sh7FFF;
    end
    hand_val = 34'h0_FFFC_0004;
    run_job(1'b0, 1'b1, 16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      a_m[i] = 16'sh8000;
      b_m[i] = 16'sh8000;
    end
    hand_val = 34'h1_0000_0000;
    run_job(1'b0, 1'b1, 16, 1'b0);

    // Back-pressure with random input gaps
    exp_mode = 0;
    for (int i = 0; i < 16; i++) begin
      a_m[i] = DATA_W'($urandom_range(0, 65535));
      b_m[i] = DATA_W'($urandom_range(0, 65535));
    end
    fork
      run_job(1'b0, 1'b1, 16, 1'b1);
      stall_watch();
    join

    // keep_b: new A against the B already buffered
    for (int i = 0; i < 16; i++) a_m[i] = DATA_W'($urandom_range(0, 65535));
    run_job(1'b1, 1'b0, 16, 1'b0);

    // Reset in STREAM_A row 2, concurrent with an input transfer
    run_job(1'b0, 1'b1, 10, 1'b0);
    in_valid = 1'b1;
    in_data  = a_m[10];
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_done",      64'(done),      64'd0);
    chk("midrst_state",     64'(dbg_state), 64'd0);

    // After reset B is invalid, so keep_b must reload B
    for (int i = 0; i < 16; i++) begin
      a_m[i] = DATA_W'($urandom_range(0, 65535));
      b_m[i] = DATA_W'($urandom_range(0, 65535));
    end
    run_job(1'b1, 1'b1, 16, 1'b1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
